// File: rtl/seq_event_logger.sv
// Timestamped match logger: stamps each detector pulse with a free-running cycle count
// and queues it in a first-word-fall-through FIFO drained over a valid/ready port.
module seq_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     det,
    input  logic                     clr,
    output logic                     ev_valid,
    output logic [TS_W-1:0]          ev_ts,
    input  logic                     ev_ready,
    output logic [CNT_W-1:0]         ev_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [TS_W-1:0]  TS_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [TS_W-1:0]  ts_q,     ts_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             valid_q,  valid_d;
    logic [TS_W-1:0]  head_q,   head_d;
    logic [TS_W-1:0]  mem_q [DEPTH];

    logic pop;
    logic full;
    logic do_push;

    always_comb begin
        pop     = valid_q && ev_ready;
        full    = (level_q == LVL_FULL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push = det && (!full || pop);

        ts_d     = ts_q + TS_ONE;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (clr) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !pop) begin
                level_d = level_q + LVL_ONE;
            end else if (!do_push && pop) begin
                level_d = level_q - LVL_ONE;
            end
            if (det && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_ONE;
            end
            if (det && !do_push) begin
                ovf_d = 1'b1;
            end
        end

        // Head is precomputed so ev_ts comes straight from a flop; the new entry is the
        // head only when it lands in an otherwise empty FIFO.
        valid_d = (level_d != '0);
        head_d  = '0;
        if (valid_d) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = ts_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && do_push) begin
            mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign ev_valid = valid_q;
    assign ev_ts    = head_q;
    assign ev_count = count_q;
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule

// File: tb/tb_seq_event_logger.sv
// Bench for seq_event_logger: default instance driven through a scoreboard model,
// plus a narrow instance (TS_W=4, CNT_W=2) for timestamp wrap and count saturation.
module tb_seq_event_logger;

    logic        clk = 1'b0;
    logic        reset, det, clr, ev_ready;
    logic        ev_valid, overflow;
    logic [15:0] ev_ts;
    logic [7:0]  ev_count;
    logic [3:0]  level;

    logic        det_s, clr_s, ready_s;
    logic        ev_valid_s, overflow_s;
    logic [3:0]  ev_ts_s;
    logic [1:0]  ev_count_s;
    logic [3:0]  level_s;

    seq_event_logger u_dut (
        .clk(clk), .reset(reset), .det(det), .clr(clr),
        .ev_valid(ev_valid), .ev_ts(ev_ts), .ev_ready(ev_ready),
        .ev_count(ev_count), .overflow(overflow), .level(level)
    );

    seq_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .det(det_s), .clr(clr_s),
        .ev_valid(ev_valid_s), .ev_ts(ev_ts_s), .ev_ready(ready_s),
        .ev_count(ev_count_s), .overflow(overflow_s), .level(level_s)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic [15:0] m_ts;
    int          m_cnt;
    logic        m_ovf;

    // One clock of stimulus on the default instance; the expected head is popped
    // from the scoreboard and the observed head is captured before the edge.
    task automatic cycle(input logic c, input logic d, input logic r,
                         output logic popped, output logic [15:0] exp_ts,
                         output logic [15:0] obs_ts);
        clr = c; det = d; ev_ready = r;
        popped = 1'b0; exp_ts = '0; obs_ts = ev_ts;
        if (c) begin
            sb.delete(); m_cnt = 0; m_ovf = 1'b0;
        end else begin
            if (r && sb.size() > 0) begin
                popped = 1'b1; exp_ts = sb.pop_front();
            end
            if (d) begin
                if (m_cnt < 255) m_cnt++;
                if (sb.size() < 8) sb.push_back(m_ts);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
        m_ts = c ? 16'd0 : m_ts + 16'd1;
        clr = 1'b0; det = 1'b0; ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", ev_valid); end
        n_cmp++; if (ev_ts !== 16'd0) begin n_err++; $display("FAIL reset_ts got %0d want 0", ev_ts); end
        n_cmp++; if (ev_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", ev_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        reset = 1'b0;
        sb.delete(); m_cnt = 0; m_ovf = 1'b0; m_ts = 16'd0;
    endtask

    task automatic test_single();
        logic p; logic [15:0] e, o;
        repeat (5) cycle(1'b0, 1'b0, 1'b0, p, e, o);
        cycle(1'b0, 1'b1, 1'b0, p, e, o);
        n_cmp++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", ev_valid); end
        n_cmp++; if (ev_ts !== 16'd5) begin n_err++; $display("FAIL single_ts got %0d want 5", ev_ts); end
        n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL single_level got %0d want 1", level); end
        n_cmp++; if (ev_count !== 8'd1) begin n_err++; $display("FAIL single_count got %0d want 1", ev_count); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, p, e, o);
            n_cmp++; if (ev_ts !== 16'd5) begin n_err++; $display("FAIL hold_ts cyc %0d got %0d want 5", i, ev_ts); end
        end
        cycle(1'b0, 1'b0, 1'b1, p, e, o);
        n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL single_pop got %0d want %0d (popped %0b)", o, e, p); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_empty_valid got %0b want 0", ev_valid); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL single_empty_level got %0d want 0", level); end
    endtask

    task automatic test_detector();
        logic p; logic [15:0] e, o;
        logic [2:0] hist;
        logic d;
        int bits[9] = '{1, 0, 1, 0, 1, 1, 0, 1, 0};
        cycle(1'b1, 1'b0, 1'b0, p, e, o);
        hist = 3'b000;
        for (int i = 0; i < 9; i++) begin
            // Overlapping Mealy 1010 detector: fires on a 0 following 1,0,1.
            d = (bits[i] == 0) && (hist == 3'b101);
            hist = {hist[1:0], bits[i] != 0};
            cycle(1'b0, d, 1'b0, p, e, o);
        end
        n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL det_level got %0d want 2", level); end
        n_cmp++; if (ev_count !== 8'd2) begin n_err++; $display("FAIL det_count got %0d want 2", ev_count); end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 1'b1, p, e, o);
            n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL det_pop %0d got %0d want %0d", k, o, e); end
        end
    endtask

    task automatic test_back_to_back_overflow();
        logic p; logic [15:0] e, o;
        cycle(1'b1, 1'b0, 1'b0, p, e, o);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, p, e, o);
            if (i == 7) begin
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %0b want 0", overflow); end
            end
            if (i == 8) begin
                n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", level); end
                n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", overflow); end
            end
        end
        n_cmp++; if (ev_count !== 8'(m_cnt)) begin n_err++; $display("FAIL ovf_count got %0d want %0d", ev_count, m_cnt); end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b1, p, e, o);
            n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL ovf_drain %0d got %0d want %0d", k, o, e); end
        end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL ovf_drained_level got %0d want 0", level); end
    endtask

    task automatic test_full_pushpop();
        logic p; logic [15:0] e, o;
        cycle(1'b1, 1'b0, 1'b0, p, e, o);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, p, e, o);
        n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL full_level got %0d want 8", level); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, p, e, o);
            n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL full_pop %0d got %0d want %0d", i, o, e); end
            n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL full_pp_level %0d got %0d want 8", i, level); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf %0d got %0b want 0", i, overflow); end
        end
        n_cmp++; if (ev_count !== 8'd12) begin n_err++; $display("FAIL full_count got %0d want 12", ev_count); end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b1, p, e, o);
            n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL full_drain %0d got %0d want %0d", k, o, e); end
        end
    endtask

    task automatic test_clr();
        logic p; logic [15:0] e, o;
        cycle(1'b1, 1'b0, 1'b0, p, e, o);
        repeat (9) cycle(1'b0, 1'b1, 1'b0, p, e, o);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b1, p, e, o);
            n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL clr_predrain %0d got %0d want %0d", k, o, e); end
        end
        n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL clr_pre_level got %0d want 3", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_pre_ovf got %0b want 1", overflow); end
        cycle(1'b1, 1'b1, 1'b0, p, e, o);
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL clr_level got %0d want 0", level); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %0b want 0", ev_valid); end
        n_cmp++; if (ev_count !== 8'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", ev_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %0b want 0", overflow); end
        n_cmp++; if (ev_ts !== 16'd0) begin n_err++; $display("FAIL clr_ts got %0d want 0", ev_ts); end
        cycle(1'b0, 1'b1, 1'b0, p, e, o);
        n_cmp++; if (ev_valid !== 1'b1 || ev_ts !== 16'd0) begin n_err++; $display("FAIL clr_ts_restart got %0d/%0b want 0/1", ev_ts, ev_valid); end
        n_cmp++; if (ev_count !== 8'd1) begin n_err++; $display("FAIL clr_recount got %0d want 1", ev_count); end
    endtask

    task automatic test_wrap_saturate();
        logic [3:0] wexp[5] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        clr_s = 1'b1;
        @(posedge clk); #1;
        clr_s = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        det_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        det_s = 1'b0;
        n_cmp++; if (level_s !== 4'd3) begin n_err++; $display("FAIL wrap_level got %0d want 3", level_s); end
        n_cmp++; if (ev_count_s !== 2'd3) begin n_err++; $display("FAIL wrap_count3 got %0d want 3", ev_count_s); end
        det_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        det_s = 1'b0;
        n_cmp++; if (ev_count_s !== 2'd3) begin n_err++; $display("FAIL sat_count got %0d want 3", ev_count_s); end
        n_cmp++; if (level_s !== 4'd5) begin n_err++; $display("FAIL sat_level got %0d want 5", level_s); end
        ready_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ev_valid_s !== 1'b1 || ev_ts_s !== wexp[i]) begin n_err++; $display("FAIL wrap_ts %0d got %0d want %0d", i, ev_ts_s, wexp[i]); end
            @(posedge clk); #1;
        end
        ready_s = 1'b0;
        n_cmp++; if (ev_valid_s !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %0b want 0", ev_valid_s); end
    endtask

    task automatic test_async_reset();
        logic p; logic [15:0] e, o;
        cycle(1'b1, 1'b0, 1'b0, p, e, o);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, p, e, o);
        cycle(1'b0, 1'b0, 1'b1, p, e, o);
        n_cmp++; if (!p || o !== e) begin n_err++; $display("FAIL ar_pop got %0d want %0d", o, e); end
        ev_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %0b want 0", ev_valid); end
        n_cmp++; if (ev_ts !== 16'd0) begin n_err++; $display("FAIL ar_ts got %0d want 0", ev_ts); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL ar_level got %0d want 0", level); end
        n_cmp++; if (ev_count !== 8'd0) begin n_err++; $display("FAIL ar_count got %0d want 0", ev_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ar_ovf got %0b want 0", overflow); end
        ev_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete(); m_cnt = 0; m_ovf = 1'b0; m_ts = 16'd0;
        cycle(1'b0, 1'b1, 1'b0, p, e, o);
        n_cmp++; if (ev_ts !== 16'd0 || level !== 4'd1) begin n_err++; $display("FAIL ar_restart got ts %0d lvl %0d want 0/1", ev_ts, level); end
    endtask

    initial begin
        reset = 1'b1; det = 1'b0; clr = 1'b0; ev_ready = 1'b0;
        det_s = 1'b0; clr_s = 1'b0; ready_s = 1'b0;
        m_ts = 16'd0; m_cnt = 0; m_ovf = 1'b0;
        test_reset();
        test_single();
        test_detector();
        test_back_to_back_overflow();
        test_full_pushpop();
        test_clr();
        test_wrap_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
